// File: rtl/inport_mem_responder.sv
// ---------------------------------------------------------------------------
// inport_mem_responder
//
// Responder end of the inport request interface. It accepts byte-masked
// 32-bit writes and 32-bit reads, and it serves them from an internal
// 2^ADDR_W x 32 word array. Read and write latencies are programmable.
// Only one transaction can be outstanding at a time.
//
// Ports:
//   clk_i                rising-edge clock
//   rst_n_i              asynchronous active-low reset
//   inport_wr_i[3:0]     byte write mask; non-zero means a write request
//   inport_rd_i          read request
//   inport_addr_i[31:0]  byte address; bits [1:0] are ignored
//   inport_write_data_i  write data, sampled together with the request
//   inport_accept_o      one-cycle pulse: request captured
//   inport_ack_o         one-cycle pulse: transaction complete
//   inport_error_o       valid with ack: out-of-range or illegal request
//   inport_read_data_o   read data, valid with ack; 0 otherwise
//
// Optional feature (macro INPORT_RESP_STALL_EN):
//   A 16-bit LFSR inserts 0..3 STALL cycles between IDLE and ACCEPT.
//   This randomises the request-to-accept delay for initiator benches.
// ---------------------------------------------------------------------------
module inport_mem_responder #(
    parameter int ADDR_W        = 10,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  inport_wr_i,
    input  logic        inport_rd_i,
    input  logic [31:0] inport_addr_i,
    input  logic [31:0] inport_write_data_i,
    output logic        inport_accept_o,
    output logic        inport_ack_o,
    output logic        inport_error_o,
    output logic [31:0] inport_read_data_o
);

    // Reject latency values that the 4-bit counter cannot represent.
    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
        $fatal(1, "inport_mem_responder: READ_LATENCY must be in 1..15");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_write_latency
        $fatal(1, "inport_mem_responder: WRITE_LATENCY must be in 1..15");
    end

    localparam logic [3:0] RD_LAT_M1 = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LAT_M1 = 4'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WAIT,
        ST_ACK
`ifdef INPORT_RESP_STALL_EN
        , ST_STALL
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          mask_q;
    logic                is_rd_q;
    logic                err_q;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         mem_q [2**ADDR_W];

    logic                req;
    logic                req_err;
    logic                capture;

    // The word index comes from bits [ADDR_W+1:2], so byte-lane bits are dropped.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^inport_addr_i[1:0];

    assign req     = (inport_wr_i != 4'b0) || inport_rd_i;
    // Reject any address above the array and any request that is both a read and a write.
    assign req_err = (inport_addr_i[31:ADDR_W+2] != '0) ||
                     ((inport_wr_i != 4'b0) && inport_rd_i);

`ifdef INPORT_RESP_STALL_EN
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form; advances every cycle.
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        rdata_d = 32'h0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
`ifdef INPORT_RESP_STALL_EN
                    if (lfsr_q[1:0] != 2'b00) begin
                        state_d = ST_STALL;
                        cnt_d   = {2'b00, lfsr_q[1:0]};
                    end else begin
                        state_d = ST_ACCEPT;
                    end
`else
                    state_d = ST_ACCEPT;
`endif
                end
            end
`ifdef INPORT_RESP_STALL_EN
            ST_STALL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACCEPT;
                end
            end
`endif
            ST_ACCEPT: begin
                // Rejected requests complete with the read latency.
                cnt_d = (is_rd_q || err_q) ? RD_LAT_M1 : WR_LAT_M1;
                state_d = (cnt_d == 4'd0) ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Register the read word on the edge that enters ACK, so data lines up with ack.
        if (state_d == ST_ACK && state_q != ST_ACK && is_rd_q && !err_q) begin
            rdata_d = mem_q[addr_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            is_rd_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (capture) begin
                addr_q  <= inport_addr_i[ADDR_W+1:2];
                wdata_q <= inport_write_data_i;
                mask_q  <= inport_wr_i;
                is_rd_q <= inport_rd_i;
                err_q   <= req_err;
            end
        end
    end

    // NOTE: the array has no reset, which lets it map onto RAM. Reset forces the
    // state to IDLE, so an in-flight write never reaches the commit below.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_ACK && !is_rd_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    mem_q[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign inport_accept_o    = (state_q == ST_ACCEPT);
    assign inport_ack_o       = (state_q == ST_ACK);
    assign inport_error_o     = (state_q == ST_ACK) && err_q;
    assign inport_read_data_o = rdata_q;

endmodule

// File: tb/tb_inport_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for inport_mem_responder (ADDR_W=10, READ_LATENCY=3,
// WRITE_LATENCY=1). A driver issues requests and pushes each expected response
// onto a queue. A monitor on the falling edge pops the queue on every ack and
// compares the data, the error flag and the accept-to-ack latency.
// ---------------------------------------------------------------------------
module tb_inport_mem_responder;

    localparam int RL = 3;
    localparam int WL = 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  wr = 4'h0;
    logic        rd = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        accept, ack, error;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int accepts = 0;
    int acks = 0;

    exp_t        exp_q[$];
    logic [31:0] model [1024];

    inport_mem_responder #(
        .ADDR_W(10), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .inport_wr_i         (wr),
        .inport_rd_i         (rd),
        .inport_addr_i       (addr),
        .inport_write_data_i (wdata),
        .inport_accept_o     (accept),
        .inport_ack_o        (ack),
        .inport_error_o      (error),
        .inport_read_data_o  (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: counts cycles and scores every ack against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            cyc++;
            if (accept) begin
                accepts++;
                acc_cyc = cyc;
            end
            if (ack) begin
                acks++;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("ack_rdata", 64'(rdata), 64'(e.data));
                    check("ack_error", 64'(error), 64'(e.err));
                    check("acc_to_ack", 64'(cyc - acc_cyc), 64'(e.lat));
                end
            end else begin
                check("quiet_outputs", 64'({error, rdata}), 64'(0));
            end
        end
    end

    // Builds the expected response and updates the reference array for legal writes.
    function automatic exp_t expect_for(input logic [3:0] w, input logic r,
                                        input logic [31:0] a, input logic [31:0] d,
                                        input bit commit);
        exp_t e;
        logic [31:0] word;
        e.err  = (a[31:12] != 20'h0) || ((w != 4'h0) && r);
        e.data = 32'h0;
        e.lat  = (e.err || r) ? RL : WL;
        if (!e.err && r) begin
            e.data = model[a[11:2]];
        end else if (!e.err && commit) begin
            word = model[a[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (w[b]) word[b*8 +: 8] = d[b*8 +: 8];
            end
            model[a[11:2]] = word;
        end
        return e;
    endfunction

    // Drives one request. It holds the request for hold_extra extra cycles past accept.
    // If rst_after >= 0, it asserts reset that many cycles after accept instead of waiting for ack.
    task automatic drive_req(input logic [3:0] w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input int hold_extra, input int rst_after);
        int  dly;
        bit  got;
        int  a0;
        exp_t e;
        e = expect_for(w, r, a, d, rst_after < 0);
        exp_q.push_back(e);
        a0 = acks;
        @(negedge clk); #1;
        wr = w; rd = r; addr = a; wdata = d;
        got = 0;
        dly = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk); #1;
            dly++;
            if (accept) got = 1;
        end
`ifdef INPORT_RESP_STALL_EN
        check("req_to_acc_range", 64'(got && dly >= 1 && dly <= 4), 64'(1));
`else
        check("req_to_acc", 64'(got ? dly : 0), 64'(1));
`endif
        repeat (hold_extra) begin
            @(negedge clk); #1;
        end
        wr = 4'h0; rd = 1'b0;
        if (rst_after >= 0) begin
            repeat (rst_after) begin
                @(negedge clk); #1;
            end
            rst_n = 1'b0;
            #1;
            check("rst_outputs", 64'({accept, ack, error, rdata}), 64'(0));
            exp_q.delete();
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (6) @(negedge clk);
            #1;
            check("rst_no_ack", 64'(acks - a0), 64'(0));
        end else begin
            for (int i = 0; i < 40 && acks == a0; i++) begin
                @(negedge clk); #1;
            end
            check("ack_seen", 64'(acks - a0), 64'(1));
        end
    endtask

    initial begin
        int a_before, k_before;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 64'({accept, ack, error, rdata}), 64'(0));
        #2 rst_n = 1'b1;

        // 1: full write, then read back
        drive_req(4'hF, 1'b0, 32'h0, 32'h1234_5678, 0, -1);
        drive_req(4'h0, 1'b1, 32'h0, 32'h0, 0, -1);

        // 2: partial byte mask
        drive_req(4'hF, 1'b0, 32'h4, 32'hFFFF_FFFF, 0, -1);
        drive_req(4'b0101, 1'b0, 32'h4, 32'hAABB_CCDD, 0, -1);
        drive_req(4'h0, 1'b1, 32'h4, 32'h0, 0, -1);

        // 3: out-of-range read, illegal wr+rd, address unchanged afterwards
        drive_req(4'hF, 1'b0, 32'hC, 32'h0BAD_F00D, 0, -1);
        drive_req(4'h0, 1'b1, 32'h0000_1000, 32'h0, 0, -1);
        drive_req(4'hF, 1'b0, 32'h8000_0000, 32'h5555_5555, 0, -1);
        drive_req(4'hF, 1'b1, 32'hC, 32'h1111_1111, 0, -1);
        drive_req(4'h0, 1'b1, 32'hC, 32'h0, 0, -1);

        // 4: request held one cycle past accept must be a single transaction
        a_before = accepts;
        k_before = acks;
        drive_req(4'hF, 1'b0, 32'h10, 32'hCAFE_0001, 1, -1);
        repeat (6) @(negedge clk);
        #1;
        check("hold_accepts", 64'(accepts - a_before), 64'(1));
        check("hold_acks", 64'(acks - k_before), 64'(1));
        drive_req(4'h0, 1'b1, 32'h10, 32'h0, 1, -1);

        // 5: reset mid-flight drops the transaction and the write
        drive_req(4'hF, 1'b0, 32'h8, 32'h0, 0, -1);
        drive_req(4'hF, 1'b0, 32'h8, 32'hDEAD_BEEF, 0, 0);
        drive_req(4'h0, 1'b1, 32'h8, 32'h0, 0, -1);
        drive_req(4'h0, 1'b1, 32'h0, 32'h0, 0, 1);
        drive_req(4'h0, 1'b1, 32'h0, 32'h0, 0, -1);

        // 6: back-to-back traffic over 16 words
        for (int i = 0; i < 16; i++) begin
            drive_req(4'hF, 1'b0, 32'(32'h40 + 4 * i), $urandom, 0, -1);
        end
        for (int i = 0; i < 16; i++) begin
            drive_req(4'h0, 1'b1, 32'(32'h40 + 4 * i), 32'h0, 0, -1);
        end

        repeat (4) @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
